bcd_counter_multi: RTL

//   Parametrised N-digit packed-BCD up/down counter with synchronous clear, validated parallel load,

---
 rtl/bcd_counter_multi.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi: N-digit packed-BCD up/down counter.
//   Synchronous clear, validated parallel load, wrap or saturate at the range limits,
//   registered limit and load-error pulses, and a combinational cascade output.
// Parameters:
//   DIGITS - number of BCD digits (>=1), digit 0 least significant
//   WRAP   - 1: wrap 9..9 <-> 0..0 at the limits, 0: saturate
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset, clears all state
//   clr      - synchronous clear (highest priority)
//   load     - synchronous parallel load request
//   load_val - packed BCD load value, digit i at [4i+3:4i]
//   en       - count enable, one step per cycle
//   up       - 1 = increment, 0 = decrement
//   Q        - packed BCD count
//   cout     - cascade: a step this cycle would cross a limit
//   lim      - registered pulse: previous edge hit or tried to pass a limit
//   load_err - registered pulse: previous load was rejected
module bcd_counter_multi #(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  cout,
  output logic                  lim,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic         lim_q, lim_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] inc_val, dec_val;
  logic         all9, all0, load_ok;
  logic         carry, borrow;
  logic [3:0]   digit;

  // Ripple increment/decrement across the digits. At all9 the increment naturally
  // yields all0 and at all0 the decrement yields all9, which is the wrap value.
  always_comb begin
    inc_val = '0;
    dec_val = '0;
    all9    = 1'b1;
    all0    = 1'b1;
    load_ok = 1'b1;
    carry   = 1'b1;
    borrow  = 1'b1;
    digit   = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit = q_q[4*i +: 4];
      if (carry) begin
        inc_val[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      end else begin
        inc_val[4*i +: 4] = digit;
      end
      if (borrow) begin
        dec_val[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      end else begin
        dec_val[4*i +: 4] = digit;
      end
      carry  = carry & (digit == 4'd9);
      borrow = borrow & (digit == 4'd0);
      all9   = all9 & (digit == 4'd9);
      all0   = all0 & (digit == 4'd0);
      if (load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Priority: clr > load > en > hold. Both pulses default low every edge.
  always_comb begin
    q_d        = q_q;
    lim_d      = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      // A rejected load also swallows any count step on this edge.
      if (load_ok) begin
        q_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (all9) begin
          lim_d = 1'b1;
          q_d   = WRAP ? inc_val : q_q;
        end else begin
          q_d = inc_val;
        end
      end else begin
        if (all0) begin
          lim_d = 1'b1;
          q_d   = WRAP ? dec_val : q_q;
        end else begin
          q_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q        <= '0;
      lim_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      lim_q      <= lim_d;
      load_err_q <= load_err_d;
    end
  end

  assign Q        = q_q;
  assign lim      = lim_q;
  assign load_err = load_err_q;
  assign cout     = en & ~clr & ~load & (up ? all9 : all0);

endmodule
